// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// Build option: define UART_PARITY_EN to expect an even-parity bit after the data bits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Two-out-of-three majority of the mid-bit samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Clocks per oversample tick; never below one so the prescaler always advances.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int d;
        d = clk_hz / (baud * os);
        if (d < 1) begin
            d = 1;
        end else begin
            d = d;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample prescaler: one-clock stick every DIV clocks, realigned by restart
// so the first sample of a frame lands a fixed distance after the start edge.
module uart_os_tick #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic stick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             stick_r;

    // Divide counter with registered tick output; restart zeroes the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            stick_r <= 1'b0;
        end else if (restart) begin
            cnt_r   <= '0;
            stick_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            stick_r <= 1'b1;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            stick_r <= 1'b0;
        end
    end

    assign stick = stick_r;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver (8N1 by default, LSB first, idle high) with a
// one-entry valid/ready holding register and false-start/framing/overrun detection.
// Build option: define UART_PARITY_EN for an even-parity bit (11-bit frame).
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int DIV    = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SIDX_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SIDX_W-1:0] S_V0  = SIDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SIDX_W-1:0] S_V1  = SIDX_W'(OVERSAMPLE / 2);
    localparam logic [SIDX_W-1:0] S_V2  = SIDX_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SIDX_W-1:0] S_END = SIDX_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] B_LAST = BCNT_W'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
    localparam uart_state_e AFTER_DATA = PARITY;

    // Even parity: data plus parity bit must hold an even number of ones.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction
`else
    localparam uart_state_e AFTER_DATA = STOP;
`endif

    // Synchronizer and edge history
    logic rx_meta_r, rx_sync_r, rx_prev_r;
    logic fall_s;

    // Frame state
    uart_state_e          state_r, state_nxt;
    logic [SIDX_W-1:0]    sidx_r, sidx_nxt;
    logic [BCNT_W-1:0]    bitcnt_r, bitcnt_nxt;
    logic [DATA_BITS-1:0] shreg_r, shreg_nxt;
    logic                 samp0_r, samp0_nxt;
    logic                 samp1_r, samp1_nxt;
    logic                 vote_s;
    logic                 stick_s;
    logic                 restart_s;
    logic                 commit_s;
    logic                 ferr_s;
    logic                 perr_s;

    // Output registers
    logic [DATA_BITS-1:0] data_out_r;
    logic                 valid_r, busy_r, frame_err_r, overrun_r;

`ifdef UART_PARITY_EN
    logic par_bit_r, par_bit_nxt;
    logic parity_err_r;
`endif

    uart_os_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart_s),
        .stick   (stick_s)
    );

    // Two-flop synchronizer on the asynchronous line plus one history flop for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign fall_s = rx_prev_r & ~rx_sync_r;
    assign vote_s = maj3(samp0_r, samp1_r, rx_sync_r);

    // Frame state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            sidx_r   <= '0;
            bitcnt_r <= '0;
            shreg_r  <= '0;
            samp0_r  <= 1'b1;
            samp1_r  <= 1'b1;
        end else begin
            state_r  <= state_nxt;
            sidx_r   <= sidx_nxt;
            bitcnt_r <= bitcnt_nxt;
            shreg_r  <= shreg_nxt;
            samp0_r  <= samp0_nxt;
            samp1_r  <= samp1_nxt;
        end
    end

`ifdef UART_PARITY_EN
    // Received parity bit, captured at its mid-bit vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit_r <= 1'b0;
        end else begin
            par_bit_r <= par_bit_nxt;
        end
    end
`endif

    // Next-state logic: sample index, mid-bit sampling, bit assembly and frame decisions.
    always_comb begin
        state_nxt  = state_r;
        sidx_nxt   = sidx_r;
        bitcnt_nxt = bitcnt_r;
        shreg_nxt  = shreg_r;
        samp0_nxt  = samp0_r;
        samp1_nxt  = samp1_r;
        restart_s  = 1'b0;
        commit_s   = 1'b0;
        ferr_s     = 1'b0;
        perr_s     = 1'b0;
`ifdef UART_PARITY_EN
        par_bit_nxt = par_bit_r;
`endif

        // Sample index advance and early mid-bit samples while a frame is active
        if (stick_s && (state_r != IDLE)) begin
            sidx_nxt = (sidx_r == S_END) ? '0 : (sidx_r + SIDX_W'(1));
            if (sidx_r == S_V0) begin
                samp0_nxt = rx_sync_r;
            end else if (sidx_r == S_V1) begin
                samp1_nxt = rx_sync_r;
            end else begin
                samp0_nxt = samp0_r;
                samp1_nxt = samp1_r;
            end
        end else begin
            sidx_nxt = sidx_r;
        end

        case (state_r)
            IDLE: begin
                // Only an edge starts a frame; a line stuck low stays idle.
                if (fall_s) begin
                    state_nxt = START;
                    sidx_nxt  = '0;
                    restart_s = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end

            START: begin
                if (stick_s && (sidx_r == S_V2) && vote_s) begin
                    state_nxt = IDLE;
                end else if (stick_s && (sidx_r == S_END)) begin
                    state_nxt  = DATA;
                    bitcnt_nxt = '0;
                end else begin
                    state_nxt = START;
                end
            end

            DATA: begin
                if (stick_s && (sidx_r == S_V2)) begin
                    shreg_nxt[bitcnt_r] = vote_s;
                end else begin
                    shreg_nxt = shreg_r;
                end
                if (stick_s && (sidx_r == S_END)) begin
                    if (bitcnt_r == B_LAST) begin
                        state_nxt = AFTER_DATA;
                    end else begin
                        bitcnt_nxt = bitcnt_r + BCNT_W'(1);
                    end
                end else begin
                    state_nxt = DATA;
                end
            end

`ifdef UART_PARITY_EN
            PARITY: begin
                if (stick_s && (sidx_r == S_V2)) begin
                    par_bit_nxt = vote_s;
                end else begin
                    par_bit_nxt = par_bit_r;
                end
                if (stick_s && (sidx_r == S_END)) begin
                    state_nxt = STOP;
                end else begin
                    state_nxt = PARITY;
                end
            end
`endif

            STOP: begin
                // Decide at mid-bit so the next start edge can be caught promptly.
                if (stick_s && (sidx_r == S_V2)) begin
                    state_nxt = IDLE;
`ifdef UART_PARITY_EN
                    if (parity_bad(shreg_r, par_bit_r)) begin
                        perr_s = 1'b1;
                    end else if (!vote_s) begin
                        ferr_s = 1'b1;
                    end else begin
                        commit_s = 1'b1;
                    end
`else
                    if (!vote_s) begin
                        ferr_s = 1'b1;
                    end else begin
                        commit_s = 1'b1;
                    end
`endif
                end else begin
                    state_nxt = STOP;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Holding register, handshake and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r  <= '0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            busy_r      <= (state_nxt != IDLE);
            frame_err_r <= ferr_s;
            overrun_r   <= 1'b0;
            if (commit_s) begin
                if (!valid_r || ready) begin
                    data_out_r <= shreg_r;
                    valid_r    <= 1'b1;
                end else begin
                    overrun_r  <= 1'b1;
                end
            end else if (valid_r && ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

`ifdef UART_PARITY_EN
    // Parity error pulse, aligned with the other status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= perr_s;
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out  = data_out_r;
    assign valid     = valid_r;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os at DIV=4 (64 clocks per bit).
// Honors UART_PARITY_EN: frames then carry a parity bit and a parity sequence runs.
module tb_uart_rx_os;

    localparam int BIT_CLK = 64;
`ifdef UART_PARITY_EN
    localparam int BUSY_LO = 590 + BIT_CLK;
    localparam int BUSY_HI = 640 + BIT_CLK;
`else
    localparam int BUSY_LO = 590;
    localparam int BUSY_HI = 640;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks;
    int failures;

    // Event counters maintained by the monitor
    int n_xfer, n_valid, n_ferr, n_ovr, n_perr, n_busy;
    logic [7:0] last_xfer;
    // Snapshots taken by the stimulus
    int s_xfer, s_valid, s_ferr, s_ovr, s_perr, s_busy;

    uart_rx_os #(
        .CLK_HZ     (6_400_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_xfer = 0; n_valid = 0; n_ferr = 0; n_ovr = 0; n_perr = 0; n_busy = 0;
        last_xfer = 8'h00;
    end

    // Monitor on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        if (valid && ready) begin
            n_xfer    <= n_xfer + 1;
            last_xfer <= data_out;
        end
        if (valid)      n_valid <= n_valid + 1;
        if (frame_err)  n_ferr  <= n_ferr + 1;
        if (overrun)    n_ovr   <= n_ovr + 1;
        if (parity_err) n_perr  <= n_perr + 1;
        if (busy)       n_busy  <= n_busy + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic snap();
        s_xfer = n_xfer; s_valid = n_valid; s_ferr = n_ferr;
        s_ovr = n_ovr; s_perr = n_perr; s_busy = n_busy;
    endtask

    // Drives start, data (LSB first), optional parity and stop; leaves rx at the stop level
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        rx = 1'b0;
        tick(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(BIT_CLK);
        end
`ifdef UART_PARITY_EN
        rx = par_b;
        tick(BIT_CLK);
`else
        if (par_b) begin
            rx = stop_b;
        end else begin
            rx = stop_b;
        end
`endif
        rx = stop_b;
        tick(BIT_CLK);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop_b;
        int         exp_xfer;
        int         exp_ferr;
        logic [7:0] exp_last;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] tmp;
        checks = 0;
        failures = 0;
        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
        vecs[4] = '{8'hC0, 1'b0, 0, 1, 8'h5A};
        vecs[5] = '{8'h01, 1'b1, 1, 0, 8'h01};

        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        tick(3);
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_parity_err", parity_err, 0);
        rst_n = 1'b1;
        tick(10);

        // Table-driven single frames, consumer always ready
        for (int v = 0; v < 6; v++) begin
            snap();
            send_frame(vecs[v].d, vecs[v].stop_b, ^vecs[v].d);
            rx = 1'b1;
            tick(20);
            chk($sformatf("vec%0d_xfer", v), n_xfer - s_xfer, vecs[v].exp_xfer);
            chk($sformatf("vec%0d_valid_cycles", v), n_valid - s_valid, vecs[v].exp_xfer);
            chk($sformatf("vec%0d_data", v), last_xfer, vecs[v].exp_last);
            chk($sformatf("vec%0d_frame_err", v), n_ferr - s_ferr, vecs[v].exp_ferr);
            chk($sformatf("vec%0d_overrun", v), n_ovr - s_ovr, 0);
            chk($sformatf("vec%0d_parity_err", v), n_perr - s_perr, 0);
            chk($sformatf("vec%0d_busy_len", v),
                ((n_busy - s_busy) >= BUSY_LO && (n_busy - s_busy) <= BUSY_HI) ? 1 : 0, 1);
            chk($sformatf("vec%0d_idle", v), {30'd0, valid, busy}, 0);
        end

        // Overrun: stalled consumer keeps the first byte
        ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, ^8'h3C);
        rx = 1'b1;
        tick(20);
        chk("ovr_hold_valid", valid, 1);
        chk("ovr_hold_data", data_out, 8'h3C);
        send_frame(8'h81, 1'b1, ^8'h81);
        rx = 1'b1;
        tick(20);
        chk("ovr_pulse", n_ovr - s_ovr, 1);
        chk("ovr_data_kept", data_out, 8'h3C);
        chk("ovr_valid_kept", valid, 1);
        ready = 1'b1;
        tick(2);
        chk("ovr_release_valid", valid, 0);
        chk("ovr_release_xfer", n_xfer - s_xfer, 1);
        chk("ovr_release_data", last_xfer, 8'h3C);

        // False start: short low glitch
        snap();
        rx = 1'b0;
        tick(16);
        rx = 1'b1;
        tick(BIT_CLK);
        chk("glitch_busy", busy, 0);
        chk("glitch_valid", valid, 0);
        chk("glitch_frame_err", n_ferr - s_ferr, 0);
        chk("glitch_busy_seen", ((n_busy - s_busy) > 0 && (n_busy - s_busy) < BIT_CLK) ? 1 : 0, 1);
        send_frame(8'h55, 1'b1, ^8'h55);
        rx = 1'b1;
        tick(20);
        chk("glitch_next_xfer", n_xfer - s_xfer, 1);
        chk("glitch_next_data", last_xfer, 8'h55);

        // Bad stop bit followed by a line held low: one error, no retrigger
        snap();
        send_frame(8'hFF, 1'b0, ^8'hFF);
        tick(200);
        chk("low_frame_err", n_ferr - s_ferr, 1);
        chk("low_valid", valid, 0);
        chk("low_busy", busy, 0);
        chk("low_no_restart", ((n_busy - s_busy) >= BUSY_LO && (n_busy - s_busy) <= BUSY_HI) ? 1 : 0, 1);
        chk("low_xfer", n_xfer - s_xfer, 0);
        rx = 1'b1;
        tick(20);
        send_frame(8'h12, 1'b1, ^8'h12);
        rx = 1'b1;
        tick(20);
        chk("low_next_data", last_xfer, 8'h12);
        chk("low_next_xfer", n_xfer - s_xfer, 1);

        // Reset in the middle of a frame
        ready = 1'b0;
        send_frame(8'h77, 1'b1, ^8'h77);
        rx = 1'b1;
        tick(20);
        chk("prerst_data", data_out, 8'h77);
        ready = 1'b1;
        tick(2);
        snap();
        tmp = 8'h0F;
        rx = 1'b0;
        tick(BIT_CLK);
        for (int i = 0; i < 3; i++) begin
            rx = tmp[i];
            tick(BIT_CLK);
        end
        rx = tmp[3];
        tick(30);
        chk("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        tick(3);
        rx = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_data", data_out, 0);
        rst_n = 1'b1;
        tick(BIT_CLK * 6);
        chk("postrst_outputs", {27'd0, valid, busy, frame_err, overrun, parity_err}, 0);
        chk("postrst_data", data_out, 0);
        send_frame(8'hC3, 1'b1, ^8'hC3);
        rx = 1'b1;
        tick(20);
        chk("postrst_xfer", n_xfer - s_xfer, 1);
        chk("postrst_new_data", last_xfer, 8'hC3);
        chk("postrst_frame_err", n_ferr - s_ferr, 0);

`ifdef UART_PARITY_EN
        // Parity: wrong bit discards the byte, right bit delivers it
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        rx = 1'b1;
        tick(20);
        chk("par_bad_pulse", n_perr - s_perr, 1);
        chk("par_bad_xfer", n_xfer - s_xfer, 0);
        chk("par_bad_valid", valid, 0);
        chk("par_bad_ferr", n_ferr - s_ferr, 0);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        rx = 1'b1;
        tick(20);
        chk("par_good_xfer", n_xfer - s_xfer, 1);
        chk("par_good_data", last_xfer, 8'h07);
        chk("par_good_perr", n_perr - s_perr, 0);
        snap();
        send_frame(8'h07, 1'b0, 1'b0);
        rx = 1'b1;
        tick(20);
        chk("par_prio_perr", n_perr - s_perr, 1);
        chk("par_prio_ferr", n_ferr - s_ferr, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
